// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO / CORDIC scheduler.
// Pure declarations: no timing or flow-control behaviour of its own.
package nco_pkg;

  typedef logic [15:0]        phase_t;
  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } sched_state_e;

  localparam int DEFAULT_AMP = 32000;

endpackage

// File: rtl/nco_next_ch.sv
// Finds the lowest set mask bit above idx, or from bit 0 when from_start is high.
// Purely combinational, zero latency; no flow control.
module nco_next_ch
  import nco_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] mask,
  input  logic [IW-1:0]  idx,
  input  logic           from_start,
  output logic           found,
  output logic [IW-1:0]  next_idx
);

  // Scan downwards so the last hit (lowest qualifying index) wins.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(idx)))) begin
        found    = 1'b1;
        next_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/nco_cordic_sched.sv
// Time-shares one CORDIC among NCH free-running phase accumulators; first sample 3+L cycles after tick.
// No backpressure: ticks during a round are dropped (err_overrun), silent CORDIC aborts a channel (err_timeout).
module nco_cordic_sched
  import nco_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int AMP     = DEFAULT_AMP,
  parameter  int TIMEOUT = 64,
  localparam int IW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  phase_t [NCH-1:0] num_i,
  input  logic   [NCH-1:0] ch_en,
  input  logic             err_clr,
  output logic             cordic_start,
  output phase_t           cordic_angle,
  output sample_t          cordic_x,
  input  logic             cordic_done,
  input  sample_t          cordic_sin,
  input  sample_t          cordic_cos,
  output logic             out_valid,
  output logic   [IW-1:0]  out_ch,
  output sample_t          out_sin,
  output sample_t          out_cos,
  output logic             busy,
  output logic             err_overrun,
  output logic             err_timeout
);

  localparam int      CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam sample_t AMP_S    = sample_t'(AMP);

  sched_state_e     state, state_d;
  phase_t [NCH-1:0] phase;
  phase_t [NCH-1:0] snap;
  logic   [NCH-1:0] snap_en;
  logic   [IW-1:0]  idx;
  logic   [CW-1:0]  wait_cnt;

  logic             take_snap;
  logic             issue;
  logic             advance;
  logic             capture;
  logic             timeout_hit;
  logic             overrun_hit;

  logic   [NCH-1:0] nx_mask;
  logic             nx_from_start;
  logic             nx_found;
  logic   [IW-1:0]  nx_idx;

  assign cordic_x = AMP_S;
  assign busy     = (state != IDLE);

  // At round start search the live enables; mid-round only the snapshot mask counts.
  assign nx_from_start = (state == IDLE);
  assign nx_mask       = (state == IDLE) ? ch_en : snap_en;

  nco_next_ch #(
    .NCH (NCH)
  ) u_next_ch (
    .mask       (nx_mask),
    .idx        (idx),
    .from_start (nx_from_start),
    .found      (nx_found),
    .next_idx   (nx_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_en[c]) begin
          phase[c] <= phase[c] + num_i[c];
        end
      end
    end
  end

  always_comb begin
    state_d     = state;
    take_snap   = 1'b0;
    issue       = 1'b0;
    advance     = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    overrun_hit = tick && (state != IDLE);
    case (state)
      IDLE: begin
        if (tick && nx_found) begin
          take_snap = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the last allowed cycle still counts as a result.
        if (cordic_done || (wait_cnt == WAIT_LAST)) begin
          capture     = cordic_done;
          timeout_hit = !cordic_done;
          advance     = 1'b1;
          state_d     = nx_found ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      snap         <= '0;
      snap_en      <= '0;
      idx          <= '0;
      wait_cnt     <= '0;
      cordic_start <= 1'b0;
      cordic_angle <= '0;
      out_valid    <= 1'b0;
      out_ch       <= '0;
      out_sin      <= '0;
      out_cos      <= '0;
      err_overrun  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_d;
      cordic_start <= issue;
      out_valid    <= capture;

      if (take_snap) begin
        snap    <= phase;
        snap_en <= ch_en;
        idx     <= nx_idx;
      end else if (advance && nx_found) begin
        idx <= nx_idx;
      end

      // Angle is registered alongside the start pulse and held through WAIT.
      if (issue) begin
        cordic_angle <= snap[idx];
        wait_cnt     <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (capture) begin
        out_sin <= cordic_sin;
        out_cos <= cordic_cos;
        out_ch  <= idx;
      end

      if (overrun_hit) begin
        err_overrun <= 1'b1;
      end else if (err_clr) begin
        err_overrun <= 1'b0;
      end

      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
    end
  end

endmodule
